// File: rtl/mmio_controller.sv
// MMIO write decoder for the board peripherals: TX byte FIFO with a drain FSM
// for the serial transmitter handshake, LED registers, status and cycle counter.
module mmio_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'h00030000,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic        core_clock,
  input  logic        reset,
  input  logic [31:0] mmio_addr,
  input  logic [1:0]  mmio_width,
  input  logic [31:0] mmio_value,
  input  logic        mmio_enable,
  output logic        mmio_write_complete,
  output logic [31:0] mmio_r_data,
  output logic [7:0]  tx_data,
  output logic        tx_data_available,
  input  logic        tx_ready,
  output logic        led_blue_control,
  output logic        led_green_control
);

  localparam int unsigned PTR_W = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_COUNT = CNT_W'(TX_FIFO_DEPTH);

  localparam logic [1:0] WRITE_BYTE = 2'b00;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       drain_state;
  logic [7:0]       tx_data_q;
  logic             led_blue_q;
  logic             led_green_q;
  logic             width_error;
  logic [31:0]      cycle_count;

  logic hit_tx, hit_blue, hit_green, hit_status, hit_cycles;
  logic is_byte, fifo_full, fifo_empty, push, pop;
  logic [7:0] fifo_head;

  always_comb begin
    hit_tx     = (mmio_addr == BASE_ADDR);
    hit_blue   = (mmio_addr == BASE_ADDR + 32'h04);
    hit_green  = (mmio_addr == BASE_ADDR + 32'h08);
    hit_status = (mmio_addr == BASE_ADDR + 32'h0C);
    hit_cycles = (mmio_addr == BASE_ADDR + 32'h10);
    is_byte    = (mmio_width == WRITE_BYTE);
    fifo_full  = (fifo_count == FIFO_FULL_COUNT);
    fifo_empty = (fifo_count == '0);
    fifo_head  = fifo_mem[rd_ptr];
  end

  // Only a byte store to a full FIFO stalls; space freed by a same-cycle pop is not reused.
  always_comb begin
    mmio_write_complete = mmio_enable && !(hit_tx && is_byte && fifo_full);
    push = mmio_enable && hit_tx && is_byte && !fifo_full;
    pop  = (drain_state == S_OFFER) && !tx_ready;
  end

  always_comb begin
    mmio_r_data = '0;
    if (hit_status) begin
      mmio_r_data[0]    = fifo_empty;
      mmio_r_data[1]    = fifo_full;
      mmio_r_data[2]    = (drain_state != S_IDLE);
      mmio_r_data[3]    = width_error;
      mmio_r_data[15:8] = 8'(fifo_count);
    end else if (hit_cycles) begin
      mmio_r_data = cycle_count;
    end else if (hit_blue) begin
      mmio_r_data[0] = led_blue_q;
    end else if (hit_green) begin
      mmio_r_data[0] = led_green_q;
    end
  end

  always_ff @(posedge core_clock) begin
    if (push) fifo_mem[wr_ptr] <= mmio_value[7:0];
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // An idle FSM also reacts to the byte being stored this cycle, so it is offered on the next edge.
  always_ff @(posedge core_clock) begin
    if (reset) begin
      drain_state <= S_IDLE;
      tx_data_q   <= '0;
    end else begin
      unique case (drain_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            drain_state <= S_OFFER;
            tx_data_q   <= fifo_head;
          end else if (push) begin
            drain_state <= S_OFFER;
            tx_data_q   <= mmio_value[7:0];
          end
        end
        S_OFFER: begin
          if (!tx_ready) drain_state <= S_BUSY;
        end
        S_BUSY: begin
          if (tx_ready) begin
            if (!fifo_empty) begin
              drain_state <= S_OFFER;
              tx_data_q   <= fifo_head;
            end else begin
              drain_state <= S_IDLE;
            end
          end
        end
        default: drain_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      led_blue_q  <= 1'b0;
      led_green_q <= 1'b0;
      width_error <= 1'b0;
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (mmio_enable && hit_blue)  led_blue_q  <= (mmio_value != 32'd0);
      if (mmio_enable && hit_green) led_green_q <= (mmio_value != 32'd0);
      if (mmio_enable && hit_tx && !is_byte) width_error <= 1'b1;
    end
  end

  always_comb begin
    tx_data           = tx_data_q;
    tx_data_available = (drain_state == S_OFFER);
    led_blue_control  = led_blue_q;
    led_green_control = led_green_q;
  end

endmodule
